mem_access: RTL and testbench

//  Memory-access pipeline stage directly downstream of the execute stage. It receives the
//  EX/MEM signals, resolves branch/jump redirects, and performs word loads/stores over a
//  req/ack data-memory bus. It then registers results into the MEM/WB pipeline register.

---
 rtl/mem_access.sv | 171 +++++++++++++++++
 tb/tb_mem_access.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: branch redirect, req/ack word load/store, and the MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned memops are trapped (o_misalign) instead of word-aligned.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pipe_TargetAddr,
  input  logic [31:0] i_pipe_AluResult,
  input  logic        i_pipe_Zero,
  input  logic [31:0] i_pipe_Reg2Data,
  input  logic [4:0]  i_pipe_RegDst,
  input  logic        i_pipe_MemToReg,
  input  logic        i_pipe_RegWrEn,
  input  logic        i_pipe_MemWrEn,
  input  logic        i_pipe_Branch,
  input  logic        i_pipe_Jump,
  output logic        o_PCSrc,
  output logic [31:0] o_BranchTarget,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        o_misalign,
`endif
  output logic [31:0] o_pipe_AluResult,
  output logic [31:0] o_pipe_MemData,
  output logic [4:0]  o_pipe_RegDst,
  output logic        o_pipe_MemToReg,
  output logic        o_pipe_RegWrEn
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_q, req_d, we_q, we_d, bus_err_q, bus_err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] wb_alu_q, wb_alu_d, wb_mdata_q, wb_mdata_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_m2r_q, wb_m2r_d, wb_rwe_q, wb_rwe_d;
  logic        memop, misalign, issue, bubble;

  assign memop = i_pipe_MemToReg | i_pipe_MemWrEn;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign   = memop & (i_pipe_AluResult[1:0] != 2'b00);
  assign o_misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign issue   = (state_q == StIdle) & memop & ~misalign;
  assign o_stall = issue | (state_q == StReq);
  // Bubble while frozen or trapped so the register file is written once per instruction.
  assign bubble  = o_stall | misalign;

  assign o_PCSrc        = (i_pipe_Branch & i_pipe_Zero) | i_pipe_Jump;
  assign o_BranchTarget = i_pipe_TargetAddr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bus_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          req_d   = 1'b1;
          we_d    = i_pipe_MemWrEn;
          addr_d  = {i_pipe_AluResult[31:2], 2'b00};
          wdata_d = i_pipe_Reg2Data;
          cnt_d   = 16'd0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (i_dmem_ack) begin
          rdata_d = i_dmem_rdata;
          req_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          rdata_d   = 32'd0;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        cnt_d   = 16'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_alu_d   = i_pipe_AluResult;
    wb_rd_d    = i_pipe_RegDst;
    wb_rwe_d   = bubble ? 1'b0 : i_pipe_RegWrEn;
    wb_m2r_d   = bubble ? 1'b0 : i_pipe_MemToReg;
    wb_mdata_d = (state_q == StResp) ? rdata_q : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      rdata_q    <= 32'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      bus_err_q  <= 1'b0;
      wb_alu_q   <= 32'd0;
      wb_mdata_q <= 32'd0;
      wb_rd_q    <= 5'd0;
      wb_m2r_q   <= 1'b0;
      wb_rwe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bus_err_q  <= bus_err_d;
      wb_alu_q   <= wb_alu_d;
      wb_mdata_q <= wb_mdata_d;
      wb_rd_q    <= wb_rd_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rwe_q   <= wb_rwe_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= (state_q == StIdle) & misalign;
  end
`endif

  assign o_dmem_req       = req_q;
  assign o_dmem_we        = we_q;
  assign o_dmem_addr      = addr_q;
  assign o_dmem_wdata     = wdata_q;
  assign o_bus_err        = bus_err_q;
  assign o_pipe_AluResult = wb_alu_q;
  assign o_pipe_MemData   = wb_mdata_q;
  assign o_pipe_RegDst    = wb_rd_q;
  assign o_pipe_MemToReg  = wb_m2r_q;
  assign o_pipe_RegWrEn   = wb_rwe_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access: expected writebacks and bus requests are queued at
// issue and popped by an independent monitor; a behavioural memory responder answers the bus.
module tb_mem_access;
  localparam int unsigned TO = 8;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] tgt, alu, r2, rdata;
  logic [4:0]  rd;
  logic zero, m2r, rwe, mwe, br, jmp, ack;
  logic pcsrc, stall, req, we, bus_err;
  logic [31:0] btgt, addr, wdata, p_alu, p_mdata;
  logic [4:0]  p_rd;
  logic p_m2r, p_rwe;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misal;
`endif

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_pipe_TargetAddr(tgt), .i_pipe_AluResult(alu), .i_pipe_Zero(zero),
    .i_pipe_Reg2Data(r2), .i_pipe_RegDst(rd), .i_pipe_MemToReg(m2r),
    .i_pipe_RegWrEn(rwe), .i_pipe_MemWrEn(mwe), .i_pipe_Branch(br), .i_pipe_Jump(jmp),
    .o_PCSrc(pcsrc), .o_BranchTarget(btgt), .o_stall(stall),
    .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr), .o_dmem_wdata(wdata),
    .i_dmem_ack(ack), .i_dmem_rdata(rdata), .o_bus_err(bus_err),
`ifdef MEM_MISALIGN_TRAP_EN
    .o_misalign(misal),
`endif
    .o_pipe_AluResult(p_alu), .o_pipe_MemData(p_mdata), .o_pipe_RegDst(p_rd),
    .o_pipe_MemToReg(p_m2r), .o_pipe_RegWrEn(p_rwe)
  );

  int checks = 0, errors = 0;
  int exp_err = 0, seen_err = 0, exp_mis = 0, seen_mis = 0;
  int plan_wait = -1;
  bit manual = 1'b0;

  typedef struct { logic [31:0] alu; logic [31:0] mdata; logic [4:0] rd; logic m2r; } wb_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic we; } bus_t;
  wb_t  wb_q[$];
  bus_t bus_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] resp_mem  [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  // Memory responder: acks after plan_wait extra cycles, never when plan_wait < 0.
  initial begin
    int req_cyc = 0;
    ack = 1'b0;
    rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!manual) begin
        if (req === 1'b1) begin
          if (plan_wait >= 0 && req_cyc == plan_wait) begin
            ack = 1'b1;
            if (we) begin
              resp_mem[addr] = wdata;
              rdata = 32'd0;
            end else begin
              rdata = resp_mem.exists(addr) ? resp_mem[addr] : init_word(addr);
            end
          end else begin
            ack = 1'b0;
          end
          req_cyc++;
        end else begin
          ack = 1'b0;
          req_cyc = 0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the stage presents a writeback or starts a bus access.
  initial begin
    logic prev_req = 1'b0, prev_err = 1'b0;
    wb_t  w;
    bus_t b;
    forever begin
      @(negedge clk);
      if (p_rwe === 1'b1) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected actual=rd%0d alu=%h required=no_write", p_rd, p_alu);
        end else begin
          w = wb_q.pop_front();
          chk("wb_alu", p_alu, w.alu);
          chk("wb_mdata", p_mdata, w.mdata);
          chk("wb_rd", {27'd0, p_rd}, {27'd0, w.rd});
          chk("wb_m2r", {31'd0, p_m2r}, {31'd0, w.m2r});
        end
      end
      if (req === 1'b1 && !prev_req) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected actual=%h required=no_request", addr);
        end else begin
          b = bus_q.pop_front();
          chk("bus_addr", addr, b.addr);
          chk("bus_we", {31'd0, we}, {31'd0, b.we});
          if (b.we) chk("bus_wdata", wdata, b.wdata);
        end
      end
      if (bus_err === 1'b1) begin
        seen_err++;
        if (prev_err) begin
          checks++; errors++;
          $display("FAIL bus_err_width actual=2+ required=1");
        end
      end
`ifdef MEM_MISALIGN_TRAP_EN
      if (misal === 1'b1) seen_mis++;
`endif
      prev_req = req;
      prev_err = bus_err;
    end
  end

  task automatic idle();
    tgt = 0; alu = 0; r2 = 0; rd = 0;
    zero = 0; m2r = 0; rwe = 0; mwe = 0; br = 0; jmp = 0;
  endtask

  // Issues one instruction, records expectations, and waits until the stage accepts it.
  task automatic do_op(input logic [31:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r, input logic z, input logic lm, input logic wr,
                       input logic sm, input logic b, input logic j, input int wt);
    logic memop, mis, tmo, s;
    logic [31:0] wa;
    int exp_lat, cyc;
    wb_t  w;
    bus_t bx;
    memop = lm | sm;
    wa    = {a[31:2], 2'b00};
    mis   = TrapEn && memop && (a[1:0] != 2'b00);
    tmo   = memop && !mis && (wt < 0);
    exp_lat = (!memop || mis) ? 1 : (tmo ? int'(TO) + 2 : 3 + wt);
    if (wr && !mis) begin
      w.alu = a; w.rd = r; w.m2r = lm;
      w.mdata = (!memop || tmo || !lm) ? 32'd0 : model_rd(wa);
      wb_q.push_back(w);
    end
    if (memop && !mis) begin
      bx.addr = wa; bx.wdata = d; bx.we = sm;
      bus_q.push_back(bx);
    end
    if (tmo) exp_err++;
    if (mis) exp_mis++;
    if (sm && !mis && !tmo) model_mem[wa] = d;
    tgt = t; alu = a; r2 = d; rd = r; zero = z; m2r = lm; rwe = wr; mwe = sm; br = b; jmp = j;
    plan_wait = wt;
    #1;
    chk("pcsrc", {31'd0, pcsrc}, {31'd0, (b & z) | j});
    chk("branch_target", btgt, t);
    cyc = 0;
    forever begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      cyc++;
      if (!s) break;
      if (cyc > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=%0d required=%0d", cyc, exp_lat);
        break;
      end
    end
    #1 idle();
    chk("latency", cyc, exp_lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rv;
    int k, wt;
    idle();
    reset = 1'b1;
    model_mem[32'h100] = 32'hCAFE_F00D;
    resp_mem[32'h100]  = 32'hCAFE_F00D;
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_pipe_alu", p_alu, 32'd0);
    chk("rst_pipe_rwe", {31'd0, p_rwe}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_op(32'h0, 32'h10, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_op(32'h0, 32'h100, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_op(32'h0, 32'h204, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    do_op(32'h0, 32'h204, 32'h0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    do_op(32'h0, 32'h180, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    do_op(32'h40, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    do_op(32'h40, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    do_op(32'h88, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    do_op(32'h0, 32'h102, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Reset during REQ: bus drops at once, a later ack does nothing
    begin
      bus_t bx;
      bx.addr = 32'h300; bx.wdata = 32'h0; bx.we = 1'b0;
      bus_q.push_back(bx);
    end
    alu = 32'h300; m2r = 1'b1; rwe = 1'b1; rd = 5'd7; plan_wait = -1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, req}, 32'd0);
    chk("rst_mid_addr", addr, 32'd0);
    chk("rst_mid_pipe_rwe", {31'd0, p_rwe}, 32'd0);
    chk("rst_mid_pipe_alu", p_alu, 32'd0);
    chk("rst_mid_bus_err", {31'd0, bus_err}, 32'd0);
    idle();
    @(posedge clk);
    #2 reset = 1'b0;
    manual = 1'b1;
    @(negedge clk); ack = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk); ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_ack_req", {31'd0, req}, 32'd0);
      chk("post_ack_stall", {31'd0, stall}, 32'd0);
      chk("post_ack_mdata", p_mdata, 32'd0);
    end
    manual = 1'b0;
    @(posedge clk); #1;

    // Randomized stream
    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 3);
      ra = 32'h200 + 32'(4 * $urandom_range(0, 15)) + (TrapEn ? 32'd0 : 32'($urandom_range(0, 3)));
      rv = $urandom;
      wt = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      case (k)
        1: do_op($urandom, ra, rv, 5'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0,
                 1'($urandom), 1'b0, wt);
        2: do_op($urandom, ra, rv, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1,
                 1'($urandom), 1'($urandom), wt);
        default: do_op($urandom, $urandom, rv, 5'($urandom), 1'($urandom), 1'b0,
                       1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 0);
      endcase
    end

    repeat (4) @(posedge clk);
    #1;
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);
    chk("bus_err_count", seen_err, exp_err);
    chk("misalign_count", seen_mis, exp_mis);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
